// File: rtl/alu_driver.sv
// Command/response wrapper that drives a fixed-latency ALU and captures its result.
// Optional Error-flag event counter enabled by defining ALU_DRIVER_ERRCNT_EN.
module alu_driver #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_op,
  input  logic       cmd_mode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_mode,
  input  logic [7:0] alu_res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  input  logic       err_clr,
  output logic [7:0] err_count
);

  // Counter must reach LATENCY without wrapping.
  localparam int unsigned CNT_W = $clog2(LATENCY + 2);
  localparam int unsigned RES_W = 8;
  localparam int unsigned ERR_BIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         alu_a_q;
  logic [3:0]         alu_b_q;
  logic [3:0]         alu_op_q;
  logic               alu_mode_q;
  logic [RES_W-1:0]   rsp_data_q;
  logic               rsp_valid_q;
  logic               cmd_ready_q;
  logic               capture_c;

  assign capture_c = (state_q == WAIT) && (cnt_q == CNT_W'(LATENCY));

  // Control FSM with registered handshake and ALU drive outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_mode_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_op_q    <= cmd_op;
            alu_mode_q  <= cmd_mode;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (capture_c) begin
            rsp_data_q  <= alu_res;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          // Return to IDLE only; a waiting command is taken on the next edge.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_mode  = alu_mode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef ALU_DRIVER_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Saturating count of captured Error flags; clear has priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (capture_c && alu_res[ERR_BIT] && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = 8'h00;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Directed self-checking bench for alu_driver with a behavioural pipelined ALU.
module tb_alu_driver;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [3:0] cmd_op = '0;
  logic       cmd_mode = 1'b0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_mode;
  logic [7:0] alu_res;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       err_clr = 1'b0;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  alu_driver #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {Zero,Carry,Sign,Error,Result}
  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [3:0] op, logic m);
    logic [4:0] s;
    logic [3:0] r;
    logic c, sg, e;
    s = '0; r = '0; c = 1'b0; sg = 1'b0; e = 1'b0;
    if (!m) begin
      case (op)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
        4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; sg = s[4]; end
        4'd3: begin
          if (b == 4'd0) begin e = 1'b1; r = 4'd0; end
          else r = a / b;
        end
        default: r = 4'd0;
      endcase
    end else begin
      case (op)
        4'd3: r = (a > b) ? a : b;
        default: r = 4'd0;
      endcase
    end
    return {(r == 4'd0), c, sg, e, r};
  endfunction

  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_a, alu_b, alu_op, alu_mode);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_res = pipe[LAT-1];

`ifdef ALU_DRIVER_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] op, input logic m);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = m; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_drive"}, 32'({alu_a, alu_b, alu_op, alu_mode}), 32'({a, b, op, m}));
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(LAT + 1));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
  endtask

  task automatic complete(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done"}, 32'({rsp_valid, cmd_ready}), 32'b01);
  endtask

  initial begin
    // Reset state, asserted between clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_mode}), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Add 3+4 -> 0x07
    send_cmd("add", 4'd3, 4'd4, 4'd0, 1'b0);
    wait_rsp("add", 8'h07);
    complete("add");

    // Add with carry 9+8 -> result 1, Carry -> 0x41
    send_cmd("addc", 4'd9, 4'd8, 4'd0, 1'b0);
    wait_rsp("addc", 8'h41);
    complete("addc");

    // Divide by zero -> Zero|Error -> 0x90
    chk("div0_err_before", 32'(err_count), 32'd0);
    send_cmd("div0", 4'd5, 4'd0, 4'd3, 1'b0);
    wait_rsp("div0", 8'h90);
    chk("div0_err_after", 32'(err_count), ERRCNT ? 32'd1 : 32'd0);
    complete("div0");

    // NPU max(9,6) -> 0x09
    send_cmd("npu", 4'd9, 4'd6, 4'd3, 1'b1);
    wait_rsp("npu", 8'h09);
    complete("npu");

    // Backpressure with a competing command held
    send_cmd("bp", 4'd2, 4'd5, 4'd0, 1'b0);
    wait_rsp("bp", 8'h07);
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 4'd0; cmd_mode = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", 32'({rsp_valid, cmd_ready, rsp_data}), 32'({1'b1, 1'b0, 8'h07}));
      chk("bp_alu", 32'({alu_a, alu_b, alu_op, alu_mode}), 32'({4'd2, 4'd5, 4'd0, 1'b0}));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_complete", 32'({rsp_valid, cmd_ready}), 32'b01);
    chk("bp_not_taken", 32'({alu_a, alu_b}), 32'({4'd2, 4'd5}));
    tick();
    cmd_valid = 1'b0;
    chk("bp_taken", 32'({cmd_ready, alu_a, alu_b}), 32'({1'b0, 4'd1, 4'd1}));
    wait_rsp("bp2", 8'h02);
    complete("bp2");

    // Reset mid-WAIT aborts the operation
    send_cmd("rstw", 4'd7, 4'd1, 4'd0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_alu", 32'({alu_a, alu_b, alu_op, alu_mode}), 32'd0);
    chk("rstw_err", 32'(err_count), 32'd0);
    chk("rstw_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rstw_no_rsp", 32'({rsp_valid, cmd_ready}), 32'b01);
    end

    // Saturation after 260 Error responses
    for (int i = 0; i < 260; i++) begin
      send_cmd("sat", 4'd5, 4'd0, 4'd3, 1'b0);
      wait_rsp("sat", 8'h90);
      complete("sat");
    end
    chk("sat_count", 32'(err_count), ERRCNT ? 32'd255 : 32'd0);

    // Clear wins over a simultaneous Error capture
    send_cmd("clr", 4'd5, 4'd0, 4'd3, 1'b0);
    repeat (LAT) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_capture", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h90}));
    chk("clr_count", 32'(err_count), 32'd0);
    complete("clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
